mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits directly upstream of the per-port memory ready logic, between the CPU datapath and the single physical memory port.
- Arbitrates instruction-fetch and data requests onto one pmem interface.
- Latches each granted transaction and returns a clean one-cycle i_resp/d_resp pulse with registered read data.
- Response pulses are guaranteed low for at least two cycles between transactions, so downstream rising-edge detection of mem_resp is reliable.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, data width in bits.
- MASK_W, DATA_W/8, byte-enable width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_read  in  1  instruction fetch request; held until i_resp.
- i_address  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetch data, registered; valid while i_resp=1.
- i_resp  out  1  one-cycle fetch completion pulse.
- d_read  in  1  data read request; held until d_resp.
- d_write  in  1  data write request; held until d_resp.
- d_address  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_wmask  in  MASK_W  write byte enables.
- d_rdata  out  DATA_W  data read result, registered.
- d_resp  out  1  one-cycle data completion pulse.
- pmem_read  out  1  memory read strobe, registered.
- pmem_write  out  1  memory write strobe, registered.
- pmem_address  out  ADDR_W  latched address.
- pmem_wdata  out  DATA_W  latched write data.
- pmem_wmask  out  MASK_W  latched byte enables.
- pmem_rdata  in  DATA_W  memory read data; valid with pmem_resp.
- pmem_resp  in  1  memory completion; may take 1..N cycles.

Behaviour:
- Reset (async, any time, including mid-transaction):
  - state=IDLE.
  - All outputs 0: rdata registers, resp, pmem strobes, pmem address/data/mask.
  - Any outstanding pmem transaction is abandoned.
- FSM states: IDLE, I_ACC, D_ACC, RESPOND, RECOVER.
- IDLE:
  - Grant decision uses the priority below.
  - On grant, latch address/wdata/wmask and operation type at the clock edge; next state is I_ACC or D_ACC.
  - No request pending: stay in IDLE.
- I_ACC / D_ACC:
  - pmem_read or pmem_write held 1 with latched fields stable.
  - On pmem_resp=1: capture pmem_rdata into i_rdata or d_rdata (reads only; d_rdata is unchanged on a write), drop the strobe, go to RESPOND.
- RESPOND: exactly one cycle with i_resp or d_resp = 1 for the granted port; then RECOVER.
- RECOVER:
  - One cycle, requests ignored, so the requester can deassert.
  - Then IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 -> strobe high cycles 1..k, where pmem_resp arrives in cycle k.
  - resp pulse in cycle k+1.
  - Next grant evaluated in cycle k+3 at the earliest.
- pmem_resp outside I_ACC/D_ACC: ignored.
- d_read and d_write both 1: treated as a write. A simulation-only assertion fires.
- Request inputs changing during I_ACC/D_ACC have no effect, because the transaction fields are latched.
- Response outputs are never both 1 in the same cycle.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - A 1-bit last_grant register (reset: instruction) flips priority.
  - When both ports request in IDLE, the port not granted last wins.
  - A single requester always wins.
- Undefined: fixed priority, data over instruction.

Decomposition:
- mem_arb_pkg holds:
  - enum arb_state_t {IDLE, I_ACC, D_ACC, RESPOND, RECOVER};
  - enum grant_t {GRANT_I, GRANT_D};
  - default width localparams.
- One sub-module, mem_arb_grant: combinational grant select, plus the last_grant register under MEM_ARB_RR_EN.

Test Plan:
- Fetch with 3-cycle memory: i_read=1, i_address=0x0040, pmem_rdata=0x1234 on pmem_resp in cycle 3 -> pmem_read=1 with pmem_address=0x0040 in cycles 1-3, i_resp=1 and i_rdata=0x1234 in cycle 4 only, next grant no earlier than cycle 6.
- Masked write: d_write=1, d_address=0x1000, d_wdata=0xBEEF, d_wmask=2'b10 -> pmem_write=1 with latched values until pmem_resp, d_resp single pulse, d_rdata unchanged.
- Contention, fixed priority: i_read and d_read both asserted in IDLE -> data served first, fetch served after RECOVER.
  - With MEM_ARB_RR_EN defined, repeat back-to-back: grants alternate D,I,D,I after an initial I.
- Mid-transaction reset: assert rst in cycle 2 of D_ACC -> all outputs 0 asynchronously; a later pmem_resp=1 in IDLE produces no resp; a fresh request then completes normally.
- Held stale request: requester keeps i_read=1 one cycle after i_resp -> no second grant (RECOVER absorbs it); i_resp stays 0 for at least 2 cycles between pulses.
- Single-cycle memory: pmem_resp=1 in cycle 1 -> i_resp in cycle 2; strobe high exactly 1 cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default widths for the memory arbiter slice.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 16;
   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned MASK_W_DEF = DATA_W_DEF / 8;

   typedef enum logic [2:0] {
      IDLE,
      I_ACC,
      D_ACC,
      RESPOND,
      RECOVER
   } arb_state_t;

   typedef enum logic {
      GRANT_I,
      GRANT_D
   } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and physical memory port of the arbiter.
// The slave modport is the arbiter's view; master is the CPU/memory side.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned MASK_W = DATA_W / 8
);
   // instruction-fetch port
   logic              i_read;
   logic [ADDR_W-1:0] i_address;
   logic [DATA_W-1:0] i_rdata;
   logic              i_resp;
   // data port
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_address;
   logic [DATA_W-1:0] d_wdata;
   logic [MASK_W-1:0] d_wmask;
   logic [DATA_W-1:0] d_rdata;
   logic              d_resp;
   // physical memory port
   logic              pmem_read;
   logic              pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [DATA_W-1:0] pmem_wdata;
   logic [MASK_W-1:0] pmem_wmask;
   logic [DATA_W-1:0] pmem_rdata;
   logic              pmem_resp;

   modport slave (
      input  i_read, i_address,
      output i_rdata, i_resp,
      input  d_read, d_write, d_address, d_wdata, d_wmask,
      output d_rdata, d_resp,
      output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask,
      input  pmem_rdata, pmem_resp
   );

   modport master (
      output i_read, i_address,
      input  i_rdata, i_resp,
      output d_read, d_write, d_address, d_wdata, d_wmask,
      input  d_rdata, d_resp,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask,
      output pmem_rdata, pmem_resp
   );

endinterface

// File: rtl/mem_arb_grant.sv
// mem_arb_grant: picks which port wins when the arbiter is idle.
// Default: fixed priority, data over instruction.
// MEM_ARB_RR_EN: round robin on contention using a last_grant register.
module mem_arb_grant
   import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
   input  logic   clk,
   input  logic   rst,
   input  logic   idle,
`endif
   input  logic   i_req,
   input  logic   d_req,
   output logic   grant_valid,
   output grant_t grant
);

`ifdef MEM_ARB_RR_EN
   grant_t last_grant_q, last_grant_d;

   // contention goes to the port not granted last; a lone requester always wins
   always_comb begin
      grant_valid  = i_req | d_req;
      if (i_req && d_req) begin
         grant = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
      end else if (d_req) begin
         grant = GRANT_D;
      end else begin
         grant = GRANT_I;
      end
      last_grant_d = last_grant_q;
      if (idle && grant_valid) begin
         last_grant_d = grant;
      end
   end

   // remember the most recent grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= GRANT_I;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`else
   // fixed priority: data port first
   always_comb begin
      grant_valid = i_req | d_req;
      grant       = d_req ? GRANT_D : GRANT_I;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates fetch and data requests onto one physical memory port.
// Each grant is latched, the memory strobe held until pmem_resp, then a single
// registered resp pulse is returned followed by a recovery cycle.
// Optional macro MEM_ARB_RR_EN selects round-robin arbitration.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned MASK_W = DATA_W / 8
)(
   input logic           clk,
   input logic           rst,
   mem_arbiter_if.slave  bus
);

   arb_state_t        state_q, state_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              i_resp_q, i_resp_d;
   logic              d_resp_q, d_resp_d;
   logic              pmem_read_q, pmem_read_d;
   logic              pmem_write_q, pmem_write_d;
   logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
   logic [DATA_W-1:0] pmem_wdata_q, pmem_wdata_d;
   logic [MASK_W-1:0] pmem_wmask_q, pmem_wmask_d;

   logic   d_req;
   logic   grant_valid;
   grant_t grant;

   assign d_req = bus.d_read | bus.d_write;

   mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
      .clk         (clk),
      .rst         (rst),
      .idle        (state_q == IDLE),
`endif
      .i_req       (bus.i_read),
      .d_req       (d_req),
      .grant_valid (grant_valid),
      .grant       (grant)
   );

   // next-state and registered-output computation
   always_comb begin
      state_d        = state_q;
      i_rdata_d      = i_rdata_q;
      d_rdata_d      = d_rdata_q;
      i_resp_d       = 1'b0;
      d_resp_d       = 1'b0;
      pmem_read_d    = pmem_read_q;
      pmem_write_d   = pmem_write_q;
      pmem_address_d = pmem_address_q;
      pmem_wdata_d   = pmem_wdata_q;
      pmem_wmask_d   = pmem_wmask_q;

      unique case (state_q)
         IDLE: begin
            if (grant_valid) begin
               if (grant == GRANT_D) begin
                  // a simultaneous read+write is treated as a write
                  pmem_write_d   = bus.d_write;
                  pmem_read_d    = ~bus.d_write;
                  pmem_address_d = bus.d_address;
                  pmem_wdata_d   = bus.d_wdata;
                  pmem_wmask_d   = bus.d_wmask;
                  state_d        = D_ACC;
               end else begin
                  pmem_read_d    = 1'b1;
                  pmem_write_d   = 1'b0;
                  pmem_address_d = bus.i_address;
                  pmem_wdata_d   = '0;
                  pmem_wmask_d   = '0;
                  state_d        = I_ACC;
               end
            end
         end
         I_ACC: begin
            if (bus.pmem_resp) begin
               i_rdata_d   = bus.pmem_rdata;
               i_resp_d    = 1'b1;
               pmem_read_d = 1'b0;
               state_d     = RESPOND;
            end
         end
         D_ACC: begin
            if (bus.pmem_resp) begin
               if (!pmem_write_q) begin
                  d_rdata_d = bus.pmem_rdata;
               end
               d_resp_d     = 1'b1;
               pmem_read_d  = 1'b0;
               pmem_write_d = 1'b0;
               state_d      = RESPOND;
            end
         end
         // resp pulse is already on the outputs; it drops next cycle
         RESPOND: state_d = RECOVER;
         // requests ignored here so a requester can deassert
         RECOVER: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state and output registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         i_rdata_q      <= '0;
         d_rdata_q      <= '0;
         i_resp_q       <= 1'b0;
         d_resp_q       <= 1'b0;
         pmem_read_q    <= 1'b0;
         pmem_write_q   <= 1'b0;
         pmem_address_q <= '0;
         pmem_wdata_q   <= '0;
         pmem_wmask_q   <= '0;
      end else begin
         state_q        <= state_d;
         i_rdata_q      <= i_rdata_d;
         d_rdata_q      <= d_rdata_d;
         i_resp_q       <= i_resp_d;
         d_resp_q       <= d_resp_d;
         pmem_read_q    <= pmem_read_d;
         pmem_write_q   <= pmem_write_d;
         pmem_address_q <= pmem_address_d;
         pmem_wdata_q   <= pmem_wdata_d;
         pmem_wmask_q   <= pmem_wmask_d;
      end
   end

   assign bus.i_rdata      = i_rdata_q;
   assign bus.d_rdata      = d_rdata_q;
   assign bus.i_resp       = i_resp_q;
   assign bus.d_resp       = d_resp_q;
   assign bus.pmem_read    = pmem_read_q;
   assign bus.pmem_write   = pmem_write_q;
   assign bus.pmem_address = pmem_address_q;
   assign bus.pmem_wdata   = pmem_wdata_q;
   assign bus.pmem_wmask   = pmem_wmask_q;

   // the data port should never request a read and a write at once
   a_no_rd_wr: assert property (@(posedge clk) disable iff (rst)
      !(bus.d_read && bus.d_write));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, checked against a
// transaction-level model of grant order, strobe timing and response data.
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mem_arbiter_if bus ();

   mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;

   // requester / model state
   bit          pi, pd, pd_wr, stale_i;
   logic [15:0] pi_addr, pd_addr, pd_wdata;
   logic [1:0]  pd_wmask;
   bit          last_d;     // model: last granted port was data
   logic [15:0] exp_i, exp_d;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic apply_reqs();
      bus.i_read    = pi | stale_i;
      bus.i_address = pi_addr;
      bus.d_read    = pd & ~pd_wr;
      bus.d_write   = pd & pd_wr;
      bus.d_address = pd_addr;
      bus.d_wdata   = pd_wdata;
      bus.d_wmask   = pd_wmask;
   endtask

   task automatic model_reset();
      pi = 0; pd = 0; pd_wr = 0; stale_i = 0;
      last_d = 0;
      exp_i = '0; exp_d = '0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_resp"},   32'({bus.i_resp, bus.d_resp}), 0);
      check({tag, "_strobe"}, 32'({bus.pmem_read, bus.pmem_write}), 0);
   endtask

   // Entry: at the negedge of the cycle in which the arbiter is idle with
   // requests applied. Exit: at the negedge of the first idle cycle after.
   task automatic do_txn(input int unsigned k, input bit hold, input logic [15:0] rd);
      bit          wd, wr;
      logic [15:0] a, wdat;
      logic [1:0]  wm;
`ifdef MEM_ARB_RR_EN
      wd = (pi && pd) ? !last_d : pd;
`else
      wd = pd;
`endif
      last_d = wd;
      wr   = wd && pd_wr;
      a    = wd ? pd_addr : pi_addr;
      wdat = pd_wdata;
      wm   = pd_wmask;
      tick();
      for (int unsigned c = 1; c <= k; c++) begin
         check("pmem_read",    32'(bus.pmem_read),  32'(!wr));
         check("pmem_write",   32'(bus.pmem_write), 32'(wr));
         check("pmem_address", 32'(bus.pmem_address), 32'(a));
         if (wr) begin
            check("pmem_wdata", 32'(bus.pmem_wdata), 32'(wdat));
            check("pmem_wmask", 32'(bus.pmem_wmask), 32'(wm));
         end
         check("resp_in_acc", 32'({bus.i_resp, bus.d_resp}), 0);
         if (c == k) begin
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = rd;
         end else if ($urandom_range(0, 1) == 1) begin
            // winner's request fields wander; latched values must not
            if (wd) begin
               bus.d_address = 16'($urandom);
               bus.d_wdata   = 16'($urandom);
               bus.d_wmask   = 2'($urandom);
            end else begin
               bus.i_address = 16'($urandom);
            end
         end
         tick();
      end
      // cycle k+1: response pulse
      if (!wd) exp_i = rd;
      else if (!wr) exp_d = rd;
      check("i_resp",  32'(bus.i_resp), 32'(!wd));
      check("d_resp",  32'(bus.d_resp), 32'(wd));
      check("i_rdata", 32'(bus.i_rdata), 32'(exp_i));
      check("d_rdata", 32'(bus.d_rdata), 32'(exp_d));
      check("strobe_at_resp", 32'({bus.pmem_read, bus.pmem_write}), 0);
      if (wd) pd = 0;
      else pi = 0;
      stale_i        = hold && !wd;
      bus.pmem_resp  = 1'($urandom_range(0, 1));
      bus.pmem_rdata = 16'($urandom);
      apply_reqs();
      tick();
      // cycle k+2: recovery
      check_quiet("recover");
      stale_i        = 0;
      bus.pmem_resp  = 1'($urandom_range(0, 1));
      bus.pmem_rdata = 16'($urandom);
      apply_reqs();
      tick();
      // cycle k+3: idle again
      check_quiet("idle");
      check("i_rdata_hold", 32'(bus.i_rdata), 32'(exp_i));
      check("d_rdata_hold", 32'(bus.d_rdata), 32'(exp_d));
      bus.pmem_resp = 1'b0;
   endtask

   task automatic idle_cycle();
      apply_reqs();
      tick();
      check_quiet("no_req");
   endtask

   initial begin
      model_reset();
      pi_addr = '0; pd_addr = '0; pd_wdata = '0; pd_wmask = '0;
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
      apply_reqs();
      tick();
      tick();
      check("rst_outputs", 32'({bus.i_resp, bus.d_resp, bus.pmem_read, bus.pmem_write}), 0);
      check("rst_pmem_addr", 32'(bus.pmem_address), 0);
      check("rst_rdata", 32'({bus.i_rdata, bus.d_rdata}), 0);
      rst = 1'b0;
      tick();

      // fetch, 3-cycle memory
      pi = 1; pi_addr = 16'h0040; apply_reqs();
      do_txn(3, 0, 16'h1234);
      idle_cycle();

      // masked write
      pd = 1; pd_wr = 1; pd_addr = 16'h1000; pd_wdata = 16'hBEEF; pd_wmask = 2'b10;
      apply_reqs();
      do_txn(2, 0, 16'h5A5A);

      // contention, several back-to-back rounds
      for (int r = 0; r < 4; r++) begin
         pi = 1; pi_addr = 16'(16'h0100 + r);
         pd = 1; pd_wr = 0; pd_addr = 16'(16'h2000 + r);
         apply_reqs();
         do_txn(2, 0, 16'($urandom));
         apply_reqs();
         do_txn(1, 0, 16'($urandom));
      end

      // stale fetch request held one cycle past i_resp
      pi = 1; pi_addr = 16'h0ABC; apply_reqs();
      do_txn(2, 1, 16'hCAFE);
      idle_cycle();
      idle_cycle();

      // single-cycle memory
      pi = 1; pi_addr = 16'h0F00; apply_reqs();
      do_txn(1, 0, 16'h7777);

      // reset during the second cycle of a data access
      pd = 1; pd_wr = 0; pd_addr = 16'h2222; apply_reqs();
      tick();
      check("pre_rst_read", 32'(bus.pmem_read), 1);
      tick();
      check("pre_rst_read2", 32'(bus.pmem_read), 1);
      rst = 1'b1;
      #1;
      check("async_rst_strobe", 32'({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}), 0);
      check("async_rst_addr", 32'(bus.pmem_address), 0);
      check("async_rst_rdata", 32'({bus.i_rdata, bus.d_rdata}), 0);
      model_reset();
      apply_reqs();
      tick();
      rst = 1'b0;
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = 16'hDEAD;
      tick();
      bus.pmem_resp = 1'b0;
      check_quiet("post_rst1");
      tick();
      check_quiet("post_rst2");
      check("post_rst_rdata", 32'({bus.i_rdata, bus.d_rdata}), 0);
      pd = 1; pd_wr = 0; pd_addr = 16'h3333; apply_reqs();
      do_txn(2, 0, 16'h4444);

      // randomized traffic
      for (int n = 0; n < 150; n++) begin
         if (!pi && $urandom_range(0, 2) != 0) begin
            pi = 1; pi_addr = 16'($urandom);
         end
         if (!pd && $urandom_range(0, 2) != 0) begin
            pd = 1; pd_wr = 1'($urandom_range(0, 1));
            pd_addr = 16'($urandom); pd_wdata = 16'($urandom); pd_wmask = 2'($urandom);
         end
         if (!pi && !pd) begin
            idle_cycle();
         end else begin
            apply_reqs();
            do_txn($urandom_range(1, 5), 1'($urandom_range(0, 1)), 16'($urandom));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
